// File: rtl/mux_scan_if.sv
// -----------------------------------------------------------------------------
// mux_scan_if
// Purpose : bundles the control inputs, mux feedback and frame outputs of
//           mux_scan_controller into one interface.
// Signals : start, cont, en_mask[3:0], y_in  -> controller (from master)
//           s1, s0, busy, frame[3:0], frame_valid -> from controller
// Modports: master (drives controls / observes results), slave (controller)
// -----------------------------------------------------------------------------
interface mux_scan_if;
  logic       start;
  logic       cont;
  logic [3:0] en_mask;
  logic       y_in;
  logic       s1;
  logic       s0;
  logic       busy;
  logic [3:0] frame;
  logic       frame_valid;

  modport master (
    output start, cont, en_mask, y_in,
    input  s1, s0, busy, frame, frame_valid
  );

  modport slave (
    input  start, cont, en_mask, y_in,
    output s1, s0, busy, frame, frame_valid
  );
endinterface

// File: rtl/mux_scan_controller.sv
// -----------------------------------------------------------------------------
// mux_scan_controller
// Purpose : steps the select lines of a 4:1 mux over the enabled channels in
//           ascending order, holding each for DWELL cycles, samples Y on the
//           last dwell cycle and publishes the four samples as a frame word.
// Ports   : clk  - system clock (rising edge)
//           rst  - asynchronous, active-high reset
//           bus  - mux_scan_if.slave:
//                  start, cont, en_mask[3:0], y_in (inputs)
//                  s1, s0, busy, frame[3:0], frame_valid (registered outputs)
// Params  : DWELL - cycles per channel (1..255)
//           CNT_W - dwell counter width, 2**CNT_W > DWELL
// -----------------------------------------------------------------------------
module mux_scan_controller #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  mux_scan_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_ch;
  logic [3:0]       r_mask;
  logic [3:0]       r_shadow;
  logic [3:0]       r_frame;
  logic             r_valid;

  logic             w_last;
  logic [3:0]       w_above;
  logic [3:0]       w_merged;

  // Index of the lowest set bit of a channel mask (0 when the mask is empty).
  function automatic logic [1:0] f_lowest(input logic [3:0] m);
    logic [1:0] idx;
    casez (m)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Final cycle of the current dwell.
  assign w_last   = (r_cnt == CNT_W'(DWELL - 1));
  // Enabled channels strictly above the current one.
  assign w_above  = r_mask & (4'b1110 << r_ch);
  // Shadow with the current channel's bit replaced by y_in, disabled bits zeroed.
  assign w_merged = ((r_shadow & ~(4'b0001 << r_ch)) | ({3'b000, bus.y_in} << r_ch)) & r_mask;

  assign bus.s1          = r_ch[1];
  assign bus.s0          = r_ch[0];
  assign bus.busy        = (r_state == ST_SCAN);
  assign bus.frame       = r_frame;
  assign bus.frame_valid = r_valid;

  // Scan FSM: channel sequencing, dwell counting, sampling and frame output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= {CNT_W{1'b0}};
      r_ch     <= 2'b00;
      r_mask   <= 4'b0000;
      r_shadow <= 4'b0000;
      r_frame  <= 4'b0000;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_ch  <= 2'b00;
          r_cnt <= {CNT_W{1'b0}};
          if (bus.start) begin
            if (bus.en_mask != 4'b0000) begin
              r_mask   <= bus.en_mask;
              r_ch     <= f_lowest(bus.en_mask);
              r_shadow <= 4'b0000;
              r_state  <= ST_SCAN;
            end else begin
              // Empty scan: publish an all-zero frame right away.
              r_frame <= 4'b0000;
              r_valid <= 1'b1;
            end
          end
        end

        ST_SCAN: begin
          if (w_last) begin
            r_shadow <= w_merged;
            r_cnt    <= {CNT_W{1'b0}};
            if (w_above != 4'b0000) begin
              r_ch <= f_lowest(w_above);
            end else begin
              r_frame <= w_merged;
              r_valid <= 1'b1;
              // Continuous mode chains the next frame without an idle cycle.
              if (bus.cont && (bus.en_mask != 4'b0000)) begin
                r_mask   <= bus.en_mask;
                r_ch     <= f_lowest(bus.en_mask);
                r_shadow <= 4'b0000;
              end else begin
                if (bus.cont) begin
                  r_mask <= bus.en_mask;
                end else begin
                  r_mask <= r_mask;
                end
                r_ch    <= 2'b00;
                r_state <= ST_IDLE;
              end
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_ch    <= 2'b00;
          r_cnt   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: doc/mux_scan_controller.md
Name: mux_scan_controller

Overview:
- Sequential select generator that sits directly upstream of multiplexador_4x1.
- Drives its select lines S1/S0 over the enabled channels I0..I3 in ascending order, holding each channel for DWELL cycles.
- Samples the mux output Y at the end of each dwell and assembles the four samples into a parallel frame word.
- Supports one-shot and continuous scanning.

Parameters:
- DWELL, 4, clock cycles spent on each enabled channel (legal range 1..255); Y is sampled on the last cycle.
- CNT_W, 8, width of the dwell counter; must satisfy 2^CNT_W > DWELL.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begins a scan when sampled high in IDLE; ignored otherwise.
- cont  input  1  continuous mode; sampled on the frame-completion edge.
- en_mask  input  4  channel enables; bit k enables channel Ik; latched at scan start.
- y_in  input  1  Y output of multiplexador_4x1.
- s1  output  1  select MSB to the mux (S1).
- s0  output  1  select LSB to the mux (S0).
- busy  output  1  high while in SCAN.
- frame  output  4  bit k holds the sample of channel Ik; bits of disabled channels are 0.
- frame_valid  output  1  one-cycle pulse when frame is updated.

Behaviour:
- Reset, asynchronous, takes effect immediately, including mid-scan:
  - state=IDLE, s1=s0=0, busy=0, frame=4'b0000, frame_valid=0.
  - Dwell counter, shadow register and latched mask cleared.
- States: IDLE, SCAN.
- IDLE:
  - s1=s0=0, busy=0.
  - start=1 with en_mask!=0: latch mask, load lowest enabled channel into {s1,s0}, clear dwell counter, go to SCAN.
  - start=1 with en_mask==0: frame<=0, frame_valid pulses on the next cycle, stay in IDLE.
- SCAN:
  - busy=1, {s1,s0}=current channel index (channel 2 -> s1=1, s0=0).
  - Dwell counter increments each cycle.
  - On the edge where count==DWELL-1:
    - shadow[ch] <= y_in.
    - If a higher enabled channel exists, move {s1,s0} to it and clear the counter.
    - Otherwise: frame <= shadow with the new sample merged, disabled bits forced to 0; frame_valid=1 for exactly the following cycle.
  - After the last channel:
    - cont=1: re-latch en_mask, clear shadow, restart at the lowest enabled channel with no idle cycle. If the new mask is 0, go to IDLE.
    - cont=0: go to IDLE.
- Latency: start sampled at edge t -> frame_valid high in cycle t+N*DWELL, where N = number of enabled channels. First select change is visible after edge t.
- Select changes only on dwell boundaries; s1/s0 are registered and glitch-free.
- start during SCAN is ignored. en_mask changes during SCAN are ignored until the next latch.
- DWELL=1: one channel per cycle; y_in is sampled the same cycle the select is presented.
- frame holds its value until the next completion or reset.

Test Plan:
- Reset mid-scan: DWELL=4, en_mask=1111, start, then assert rst at cycle 6 -> s1=s0=0, busy=0, frame=0000 immediately; no frame_valid afterwards.
- Full scan: DWELL=4, en_mask=1111, mux data I0=1, I1=0, I2=1, I3=1, start at t:
  - {s1,s0} = 00, 01, 10, 11 for 4 cycles each.
  - frame=1101 (bit3..bit0) with frame_valid at t+16.
  - busy deasserts the cycle after.
- Sparse mask: en_mask=1010, all data 1 -> selects visit only 01 then 11; frame=1010; frame_valid at t+8.
- Empty mask: en_mask=0000, start -> busy stays 0, frame=0000, one frame_valid pulse.
- Continuous: cont=1, en_mask=0011, data I0=1, I1=1, then en_mask changed to 0100 and I2=0 mid-frame:
  - First frame=0011.
  - Second frame uses 0100 only and gives frame=0000.
  - No idle cycle between frames.
- DWELL=1 with start pulsed during busy: selects change every cycle; extra start ignored; exactly one frame_valid per scan.
